// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Imported by pwm_multi and pwm_channel.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b0 + 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Upper bounds for the duty extractor: CNT_W <= 32 and CH_COUNT*CNT_W <= 1024.
    localparam int DUTY_W_MAX   = 32;
    localparam int DUTY_BUS_MAX = 1024;

    function automatic logic [DUTY_W_MAX-1:0] duty_of(
        input logic [DUTY_BUS_MAX-1:0] bus,
        input int                      k,
        input int                      cnt_w
    );
        logic [DUTY_W_MAX-1:0] mask;
        mask = (DUTY_W_MAX'(1) << cnt_w) - DUTY_W_MAX'(1);
        return DUTY_W_MAX'(bus >> (k * cnt_w)) & mask;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: counter-vs-duty compare, polarity, registered output.
// Drives its idle (inactive) level while the time base is disabled.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             nrst_in,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             pol_i,
    output logic             pwm_o
);

    logic pwm_d;
    logic pwm_q;

    always_comb begin
        pwm_d = pol_i;
        if (enable_i) begin
            pwm_d = (cnt_i < duty_i) ^ pol_i;
        end
    end

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler + period counter (edge or center aligned),
// double-buffered period/duty/polarity/mode committed on period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH_COUNT = 4,
    parameter int CNT_W    = 8,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      nrst_in,
    input  logic                      enable,
    input  logic                      update_req,
    input  logic [CNT_W-1:0]          period_in,
    input  logic [CH_COUNT*CNT_W-1:0] duty_in,
    input  logic [CH_COUNT-1:0]       pol_in,
    input  logic                      center_in,
    input  logic [PRESC_W-1:0]        prescale_in,
    output logic [CH_COUNT-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      update_pending,
    output logic [CNT_W-1:0]          cnt_out
);

    typedef struct packed {
        logic [CNT_W-1:0]          period;
        logic [CH_COUNT*CNT_W-1:0] duty;
        logic [CH_COUNT-1:0]       pol;
        logic                      center;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{period: '1, duty: '0, pol: '0, center: MODE_EDGE};

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    cfg_t               act_q, act_d;
    cfg_t               stg_q, stg_d;
    logic               pending_q, pending_d;
    logic               period_end_q, period_end_d;

    cfg_t cfg_in;
    logic tick;
    logic going_down;
    logic boundary;
    logic commit;

    assign cfg_in = '{period: period_in, duty: duty_in, pol: pol_in, center: center_in};

    // A lowered prescale_in below the running count wraps on the next clock.
    assign tick       = enable && (presc_q >= prescale_in);
    assign going_down = (dir_q == DIR_DOWN) || (cnt_q >= act_q.period);
    assign boundary   = (act_q.center == MODE_CENTER)
                      ? ((act_q.period == '0) || (going_down && (cnt_q == CNT_W'(1))))
                      : (cnt_q >= act_q.period);
    assign commit     = pending_q && (!enable || (tick && boundary));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        period_end_d = tick && boundary;
        if (!enable) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
        end else if (tick) begin
            presc_d = '0;
            if (boundary) begin
                cnt_d = '0;
                dir_d = DIR_UP;
            end else if ((act_q.center == MODE_CENTER) && going_down) begin
                cnt_d = cnt_q - 1'b1;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + 1'b1;
                dir_d = DIR_UP;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // A request landing on a committing cycle re-arms the stage for the next boundary.
    assign act_d     = commit ? stg_q : act_q;
    assign stg_d     = update_req ? cfg_in : stg_q;
    assign pending_d = update_req || (pending_q && !commit);

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            act_q        <= CFG_RESET;
            stg_q        <= CFG_RESET;
            pending_q    <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            act_q        <= act_d;
            stg_q        <= stg_d;
            pending_q    <= pending_d;
            period_end_q <= period_end_d;
        end
    end

    for (genvar k = 0; k < CH_COUNT; k++) begin : g_ch
        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .nrst_in (nrst_in),
            .enable_i(enable),
            .cnt_i   (cnt_q),
            .duty_i  (CNT_W'(duty_of(DUTY_BUS_MAX'(act_q.duty), k, CNT_W))),
            .pol_i   (act_q.pol[k]),
            .pwm_o   (pwm_out[k])
        );
    end

    assign period_end     = period_end_q;
    assign update_pending = pending_q;
    assign cnt_out        = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected per-period high counts are queued by the
// stimulus and checked by a monitor on every period_end pulse.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int PW = 8;

    logic              clk = 1'b0;
    logic              nrst_in;
    logic              enable;
    logic              update_req;
    logic [CW-1:0]     period_in;
    logic [CH*CW-1:0]  duty_in;
    logic [CH-1:0]     pol_in;
    logic              center_in;
    logic [PW-1:0]     prescale_in;
    logic [CH-1:0]     pwm_out;
    logic              period_end;
    logic              update_pending;
    logic [CW-1:0]     cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0]          clks;
        logic [CH-1:0][15:0]  hi;
    } rec_t;

    rec_t sb_q[$];
    int   acc_clks;
    int   acc_hi[CH];
    int   center_seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    always #5 clk = ~clk;

    pwm_multi #(.CH_COUNT(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
        .clk           (clk),
        .nrst_in       (nrst_in),
        .enable        (enable),
        .update_req    (update_req),
        .period_in     (period_in),
        .duty_in       (duty_in),
        .pol_in        (pol_in),
        .center_in     (center_in),
        .prescale_in   (prescale_in),
        .pwm_out       (pwm_out),
        .period_end    (period_end),
        .update_pending(update_pending),
        .cnt_out       (cnt_out)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CH*CW-1:0] dutys(input int d0, input int d1, input int d2, input int d3);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic push(input int clks, input int h0, input int h1, input int h2, input int h3);
        rec_t r;
        r.clks  = 16'(clks);
        r.hi[0] = 16'(h0);
        r.hi[1] = 16'(h1);
        r.hi[2] = 16'(h2);
        r.hi[3] = 16'(h3);
        sb_q.push_back(r);
    endtask

    task automatic wait_pe(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (period_end) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: no period_end within 1000 clk", name);
    endtask

    task automatic wait_cnt(input int value, input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cnt_out == CW'(value)) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: cnt_out never reached %0d", name, value);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (sb_q.size() == 0) return;
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: %0d expected periods never observed", name, sb_q.size());
        sb_q.delete();
    endtask

    task automatic set_cfg(input int p, input logic [CH*CW-1:0] d, input logic [CH-1:0] pol, input logic ctr);
        period_in = CW'(p);
        duty_in   = d;
        pol_in    = pol;
        center_in = ctr;
    endtask

    // Disable, stage a configuration and let it commit without a boundary.
    task automatic load_idle(input int p, input logic [CH*CW-1:0] d, input logic [CH-1:0] pol,
                             input logic ctr, input string name);
        @(negedge clk);
        enable = 1'b0;
        set_cfg(p, d, pol, ctr);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        check({name, "_pend_set"}, int'(update_pending), 1);
        @(negedge clk);
        check({name, "_pend_clr"}, int'(update_pending), 0);
    endtask

    // Monitor: accumulates one window per period_end and compares it with the queue head.
    initial begin
        acc_clks = 0;
        foreach (acc_hi[k]) acc_hi[k] = 0;
        forever begin
            @(negedge clk);
            if (!nrst_in) begin
                acc_clks = 0;
                foreach (acc_hi[k]) acc_hi[k] = 0;
                continue;
            end
            if (period_end) begin
                if (sb_q.size() > 0) begin
                    rec_t r;
                    r = sb_q.pop_front();
                    check("period_clks", acc_clks, int'(r.clks));
                    for (int k = 0; k < CH; k++) begin
                        check($sformatf("ch%0d_high_clks", k), acc_hi[k], int'(r.hi[k]));
                    end
                end
                acc_clks = 0;
                foreach (acc_hi[k]) acc_hi[k] = 0;
            end
            acc_clks++;
            for (int k = 0; k < CH; k++) begin
                if (pwm_out[k]) acc_hi[k]++;
            end
        end
    end

    initial begin
        nrst_in     = 1'b0;
        enable      = 1'b0;
        update_req  = 1'b0;
        prescale_in = '0;
        set_cfg(0, '0, '0, 1'b0);
        #23;
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_cnt_out", int'(cnt_out), 0);
        check("rst_pending", int'(update_pending), 0);
        check("rst_period_end", int'(period_end), 0);
        nrst_in = 1'b1;

        // Edge-aligned duties including constant-low and constant-high channels.
        load_idle(9, dutys(3, 0, 10, 5), 4'b0000, 1'b0, "edge");
        enable = 1'b1;
        wait_pe("edge");
        #1;
        repeat (3) push(10, 3, 0, 10, 5);
        drain("edge");

        // Center-aligned: 0,1,2,3,4,3,2,1 repeating.
        load_idle(4, dutys(2, 0, 8, 4), 4'b0000, 1'b1, "center");
        enable = 1'b1;
        wait_pe("center");
        check("center_cnt_0", int'(cnt_out), 0);
        #1;
        repeat (2) push(8, 3, 0, 8, 7);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("center_cnt_%0d", i), int'(cnt_out), center_seq[i]);
        end
        drain("center");

        // Prescaler: tick every 4 clk, edge period of 2 ticks.
        prescale_in = 8'd3;
        load_idle(1, dutys(1, 2, 0, 1), 4'b0000, 1'b0, "presc");
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("presc_before_first_tick", int'(cnt_out), 0);
        @(negedge clk);
        check("presc_first_tick", int'(cnt_out), 1);
        repeat (3) @(negedge clk);
        check("presc_hold", int'(cnt_out), 1);
        @(negedge clk);
        check("presc_wrap", int'(cnt_out), 0);
        wait_pe("presc");
        #1;
        repeat (2) push(8, 4, 8, 0, 4);
        drain("presc");

        // Shadowed update mid-period: old period completes, new one follows.
        prescale_in = 8'd0;
        load_idle(9, dutys(3, 0, 10, 5), 4'b0000, 1'b0, "shadow_a");
        enable = 1'b1;
        wait_pe("shadow_old");
        #1;
        push(10, 3, 0, 10, 5);
        repeat (4) @(negedge clk);
        set_cfg(19, dutys(10, 5, 25, 0), 4'b0000, 1'b0);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        check("shadow_pend_set", int'(update_pending), 1);
        push(20, 10, 5, 20, 0);
        wait_pe("shadow_commit");
        check("shadow_pend_clr", int'(update_pending), 0);

        // Stage A mid-period, then stage B exactly on the boundary tick.
        repeat (4) @(negedge clk);
        set_cfg(9, dutys(3, 0, 10, 5), 4'b0000, 1'b0);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        check("stage_a_pend", int'(update_pending), 1);
        wait_cnt(19, "stage_b_wait");
        set_cfg(14, dutys(7, 14, 15, 0), 4'b0000, 1'b0);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        check("boundary_pe", int'(period_end), 1);
        check("boundary_defer_pend", int'(update_pending), 1);
        #1;
        push(10, 3, 0, 10, 5);
        wait_pe("stage_b_commit");
        check("stage_b_pend_clr", int'(update_pending), 0);
        #1;
        push(15, 7, 14, 15, 0);
        drain("shadow");

        // Disable with new polarity: idle level and immediate commit.
        @(negedge clk);
        enable     = 1'b0;
        pol_in     = 4'b0101;
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        check("dis_pend_set", int'(update_pending), 1);
        @(negedge clk);
        check("dis_pend_clr", int'(update_pending), 0);
        @(negedge clk);
        check("dis_idle_pwm", int'(pwm_out), 'b0101);
        check("dis_cnt", int'(cnt_out), 0);
        check("dis_period_end", int'(period_end), 0);
        enable = 1'b1;
        wait_pe("pol_run");
        #1;
        repeat (2) push(15, 8, 14, 0, 0);
        drain("pol_run");

        // Asynchronous reset mid-period with an update still pending.
        @(negedge clk);
        set_cfg(50, dutys(1, 2, 3, 4), 4'b1111, 1'b1);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        check("prerst_pend", int'(update_pending), 1);
        repeat (3) @(negedge clk);
        #2;
        enable  = 1'b0;
        nrst_in = 1'b0;
        #1;
        check("arst_pwm_out", int'(pwm_out), 0);
        check("arst_cnt_out", int'(cnt_out), 0);
        check("arst_pending", int'(update_pending), 0);
        #17;
        nrst_in = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_pwm_idle", int'(pwm_out), 0);
        check("postrst_cnt", int'(cnt_out), 0);
        check("postrst_pending", int'(update_pending), 0);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_run_pwm", int'(pwm_out), 0);
        check("postrst_run_cnt", int'(cnt_out), 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
